// File: rtl/dual_line_read_scheduler.sv
// Dual-camera line read scheduler: gates the HDMI timing generator and
// interleaves the two per-camera ping-pong line buffers onto one output line.
//
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   cam_fs[1:0]        per-camera frame-start pulse (bit0 = cam0)
//   line_wr_done[1:0]  per-camera "line written into current bank" pulse
//   fv, lv             frame/line valid from the timing generator
//   tg_rstn            timing generator enable (0 holds it in reset)
//   rd_en, rd_sel      line-buffer read strobe, camera being read
//   rd_bank, rd_addr   ping-pong bank and pixel address of the read
//   synced             high while in RUN
//   underrun, overrun  sticky error flags, cleared only by rst
//   underrun_cnt[7:0]  saturating underrun event count
//                      (present only when UNDERRUN_CNT_EN is defined)
//
// Build option: define UNDERRUN_CNT_EN to add the underrun_cnt output.
module dual_line_read_scheduler #(
    parameter int LINE_PIX    = 960,
    parameter int ADDR_W      = 11,
    parameter int START_LINES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cam_fs,
    input  logic [1:0]        line_wr_done,
    input  logic              fv,
    input  logic              lv,
    output logic              tg_rstn,
    output logic              rd_en,
    output logic              rd_sel,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              synced,
    output logic              underrun,
`ifdef UNDERRUN_CNT_EN
    output logic [7:0]        underrun_cnt,
`endif
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        RESYNC
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_PIX - 1);
    localparam logic [1:0] START_C = 2'(START_LINES);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  fs_seen;
    logic [1:0]  cred0;
    logic [1:0]  cred1;
    logic [1:0]  cred0_nx;
    logic [1:0]  cred1_nx;
    logic [1:0]  bank;
    logic        lv_q;
    logic        reading;

    logic        lv_rise;
    logic        last_addr;
    logic        done0;
    logic        done1;
    logic        abort;
    logic        start_ok;
    logic        start_bad;
    logic [1:0]  inc;
    logic [1:0]  ovf;

    // Credit step: +1 saturating at 2, -1, or hold when both or neither.
    function automatic logic [1:0] cred_step(
        input logic [1:0] c,
        input logic       up,
        input logic       dn
    );
        logic [1:0] r;
        r = c;
        if (up && !dn) begin
            r = (c == 2'd2) ? 2'd2 : c + 2'd1;
        end else if (dn && !up) begin
            r = (c == 2'd0) ? 2'd0 : c - 2'd1;
        end
        return r;
    endfunction

    always_comb begin
        lv_rise   = fv & lv & ~lv_q;
        last_addr = (rd_addr == LAST);
        // cam0 half completes only if the line was not cut short on
        // that very cycle; the final cam1 beat completes regardless,
        // because lv legitimately falls while it is being read.
        done0     = reading & ~rd_sel & last_addr & lv;
        done1     = reading & rd_sel & last_addr;
        abort     = reading & ~lv & ~done1;
        start_ok  = (state == RUN) & lv_rise & ~reading
                  & (cred0 != 2'd0) & (cred1 != 2'd0);
        start_bad = (state == RUN) & lv_rise & ~reading
                  & ((cred0 == 2'd0) | (cred1 == 2'd0));
        // Writes before the camera's frame start are not counted.
        inc       = line_wr_done & fs_seen
                  & {2{state != RESYNC}};
        ovf[0]    = inc[0] & ~done0 & (cred0 == 2'd2);
        ovf[1]    = inc[1] & ~done1 & (cred1 == 2'd2);
        cred0_nx  = cred_step(cred0, inc[0], done0);
        cred1_nx  = cred_step(cred1, inc[1], done1);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (fs_seen == 2'b11) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (cred0 >= START_C && cred1 >= START_C) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (start_bad) begin
                    state_nx = RESYNC;
                end
            end
            RESYNC: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_seen  <= 2'b00;
            cred0    <= 2'd0;
            cred1    <= 2'd0;
            bank     <= 2'b00;
            lv_q     <= 1'b0;
            reading  <= 1'b0;
            rd_sel   <= 1'b0;
            rd_addr  <= '0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            lv_q <= lv;
            if (state == RESYNC) begin
                fs_seen <= 2'b00;
                cred0   <= 2'd0;
                cred1   <= 2'd0;
                bank    <= 2'b00;
                reading <= 1'b0;
                rd_sel  <= 1'b0;
                rd_addr <= '0;
            end else begin
                if (state == IDLE) begin
                    fs_seen <= fs_seen | cam_fs;
                end
                cred0   <= cred0_nx;
                cred1   <= cred1_nx;
                overrun <= overrun | (|ovf);
                if (done0) begin
                    bank[0] <= ~bank[0];
                end
                if (done1) begin
                    bank[1] <= ~bank[1];
                end
                if (start_ok) begin
                    reading <= 1'b1;
                    rd_sel  <= 1'b0;
                    rd_addr <= '0;
                end else if (abort || done1) begin
                    reading <= 1'b0;
                    rd_sel  <= 1'b0;
                    rd_addr <= '0;
                end else if (reading) begin
                    if (last_addr) begin
                        rd_sel  <= 1'b1;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                if (start_bad) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= 8'd0;
        end else if (start_bad && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        tg_rstn = (state == RUN);
        synced  = (state == RUN);
        rd_en   = reading;
        rd_bank = rd_sel ? bank[1] : bank[0];
    end

endmodule

// File: doc/dual_line_read_scheduler.md
Name: dual_line_read_scheduler

Overview:
- Sequences reads from the two per-camera ping-pong line buffers onto one side-by-side output line.
- Controls the output timing generator through its active-low enable.
- Consumes the generator's fv/lv and per-camera line-written pulses. Produces line-buffer read enable, address, camera select and bank.
- Sits between the two CSI-2 raw-to-parallel write sides and the HDMI output path.

Parameters:
- LINE_PIX, 960, active pixels per camera per line; output lv width must equal 2*LINE_PIX.
- ADDR_W, 11, line-buffer address width; LINE_PIX <= 2**ADDR_W.
- START_LINES, 2, lines each camera must have buffered before the timing generator is released; legal range 1..2.

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cam_fs  input  2  one-cycle frame-start pulse per camera (bit0 = cam0).
- line_wr_done  input  2  one-cycle pulse when a camera completes writing one line into its current bank.
- fv  input  1  frame valid from timing generator.
- lv  input  1  line valid from timing generator.
- tg_rstn  output  1  timing generator enable; 0 holds it in reset.
- rd_en  output  1  line-buffer read strobe.
- rd_sel  output  1  camera being read (0 = cam0, 1 = cam1).
- rd_bank  output  1  ping-pong bank of the selected camera.
- rd_addr  output  ADDR_W  pixel address within line.
- synced  output  1  high in RUN state.
- underrun  output  1  sticky; line started with no buffered line.
- overrun  output  1  sticky; line written while credit already 2.

Behaviour:
- Reset values: tg_rstn=0, rd_en=0, rd_sel=0, rd_bank=0, rd_addr=0, synced=0, underrun=0, overrun=0. Credits, bank pointers and fs latches are cleared. State is IDLE.
- A reset asserted mid-line aborts the read immediately, with no partial-line completion.
- Credits: each camera has a 2-bit credit counter, range 0..2.
  - Increment on line_wr_done[i].
  - Decrement when that camera's half-line read completes.
  - Increment and decrement in the same cycle leaves the credit unchanged.
  - An increment at 2 saturates and sets overrun.
- IDLE:
  - cam_fs[i] sets fs_seen[i].
  - line_wr_done is ignored until fs_seen[i] is set.
  - When both fs_seen are set, go to FILL.
- FILL:
  - Credits count.
  - When both credits >= START_LINES, go to RUN.
  - tg_rstn rises in the first RUN cycle.
- RUN:
  - synced=1 and tg_rstn=1.
  - The lv rising edge (lv=1, lv_q=0) starts a line.
  - Read latency is 1 clock: the first rd_en is in the cycle after lv is first seen high.
  - Then 2*LINE_PIX consecutive rd_en cycles:
    - LINE_PIX with rd_sel=0, rd_addr 0..LINE_PIX-1, rd_bank=bank0;
    - then LINE_PIX with rd_sel=1, rd_addr 0..LINE_PIX-1, rd_bank=bank1.
  - After the last cam0 address, credit0 decrements and bank0 toggles; the same applies to cam1 at its last address.
  - rd_en then drops and rd_addr returns to 0.
  - lv falling early aborts the line: rd_en drops, credits and banks are untouched, and the state stays RUN.
- Underrun: at an lv rising edge with either credit == 0:
  - set underrun, no reads;
  - go to RESYNC.
- RESYNC (1 cycle):
  - tg_rstn=0; credits, banks and fs_seen cleared;
  - next state IDLE.
- fv is used only to ignore lv edges while fv=0; no other fv dependency.
- cam_fs in RUN or FILL is ignored. Sticky flags clear only on rst.

Optional Feature:
- UNDERRUN_CNT_EN:
  - Defined: adds output underrun_cnt [7:0], a saturating count of underrun events (stops at 255), reset 0.
  - Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst 4 cycles, no inputs -> tg_rstn=0, all outputs 0, state stays IDLE for 100 cycles.
- Start-up: cam_fs on both, then 2 line_wr_done per camera -> tg_rstn=1 exactly 1 cycle after the second credit on the later camera; synced=1.
- Line read: lv high for 1920 cycles -> rd_en high for 1920 cycles starting 1 cycle after lv. rd_sel=0 for addr 0..959 on bank0, then rd_sel=1 for addr 0..959; afterwards both credits=1 and banks toggled.
- Simultaneous events: line_wr_done[0] coincides with the last cam0 read -> credit0 unchanged (2 stays 2 without overrun).
- Underrun: withhold cam1 writes, then present the next lv edge -> underrun=1, no rd_en, tg_rstn low 1 cycle, state IDLE; with UNDERRUN_CNT_EN, underrun_cnt=1.
- Overrun and mid-line reset: 3 writes on cam0 with no reads -> overrun=1, credit0=2. rst during a line read -> rd_en=0 on the next cycle and all state at reset values.
